// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage and the IF/ID register.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR     = 32'h8000_0000;
    localparam logic [31:0] RESET_PC      = 32'h0000_0000;
    localparam int unsigned PC_INCR       = 4;
    localparam int unsigned WORD_ADDR_LSB = 2;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_ctrl_e;

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, or replace it with a bubble.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  ifid_ctrl_e  ctrl_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] npc_i,
    output logic [31:0] instr_o,
    output logic [31:0] npc_o,
    output logic        valid_o
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] npc_d, npc_q;
    logic        valid_d, valid_q;

    always_comb begin
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        unique case (ctrl_i)
            IFID_LOAD: begin
                instr_d = instr_i;
                npc_d   = npc_i;
                valid_d = 1'b1;
            end
            IFID_BUBBLE: begin
                instr_d = NOP_INSTR;
                npc_d   = '0;
                valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            npc_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign npc_o   = npc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, applies redirect/flush/stall/halt priority and feeds IF/ID.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = fetch_pkg::RESET_PC,
    parameter int unsigned IMEM_WORDS = 32,
    parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic [31:0] ifid_instr_o,
    output logic [31:0] ifid_npc_o,
    output logic        ifid_valid_o,
    output logic        halted_o,
    output logic [31:0] fetch_count_o
);

    logic [31:0] pc_d, pc_q;
    logic        halted_d, halted_q;
    logic [31:0] count_d, count_q;
    logic [31:0] pc_plus4;
    logic        in_range;
    ifid_ctrl_e  ifid_ctrl;
    logic        unused_tgt_lsb;

    assign unused_tgt_lsb = ^branch_target_i[WORD_ADDR_LSB-1:0];
    assign pc_plus4       = pc_q + 32'(PC_INCR);
    assign in_range       = {2'b00, pc_q[31:WORD_ADDR_LSB]} < 32'(IMEM_WORDS);

    always_comb begin
        pc_d      = pc_q;
        halted_d  = halted_q;
        count_d   = count_q;
        ifid_ctrl = IFID_HOLD;
        if (branch_taken_i) begin
            pc_d      = {branch_target_i[31:WORD_ADDR_LSB], 2'b00};
            halted_d  = 1'b0;
            ifid_ctrl = IFID_BUBBLE;
        end else if (flush_i) begin
            ifid_ctrl = IFID_BUBBLE;
        end else if (stall_i) begin
            ifid_ctrl = IFID_HOLD;
        end else if (halted_q) begin
            ifid_ctrl = IFID_BUBBLE;
        end else if (!in_range) begin
            halted_d  = 1'b1;
            ifid_ctrl = IFID_BUBBLE;
        end else begin
            pc_d      = pc_plus4;
            count_d   = count_q + 32'd1;
            ifid_ctrl = IFID_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    ifid_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .ctrl_i  (ifid_ctrl),
        .instr_i (imem_data_i),
        .npc_i   (pc_plus4),
        .instr_o (ifid_instr_o),
        .npc_o   (ifid_npc_o),
        .valid_o (ifid_valid_o)
    );

    assign imem_addr_o   = pc_q;
    assign halted_o      = halted_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 32-word combinational instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic [31:0] ifid_instr_o;
    logic [31:0] ifid_npc_o;
    logic        ifid_valid_o;
    logic        halted_o;
    logic [31:0] fetch_count_o;

    logic [31:0] imem [0:31];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (32),
        .NOP_INSTR  (32'h8000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .imem_addr_o     (imem_addr_o),
        .imem_data_i     (imem_data_i),
        .ifid_instr_o    (ifid_instr_o),
        .ifid_npc_o      (ifid_npc_o),
        .ifid_valid_o    (ifid_valid_o),
        .halted_o        (halted_o),
        .fetch_count_o   (fetch_count_o)
    );

    // Word i holds 0x8C00_0000 | (i+1)<<16 | (i+1); out-of-range reads return all ones.
    always_comb begin
        imem_data_i = 32'hFFFF_FFFF;
        if (imem_addr_o[31:7] == '0)
            imem_data_i = imem[imem_addr_o[6:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] npc, input logic valid);
        check({tag, ".instr"}, ifid_instr_o, instr);
        check({tag, ".npc"},   ifid_npc_o,   npc);
        check({tag, ".valid"}, {31'd0, ifid_valid_o}, {31'd0, valid});
    endtask

    initial begin
        for (int i = 0; i < 32; i++)
            imem[i] = 32'h8C00_0000 | (32'(i + 1) << 16) | 32'(i + 1);

        #12;
        check("rst.addr", imem_addr_o, 32'h0);
        check_ifid("rst", 32'h8000_0000, 32'h0, 1'b0);
        check("rst.halted", {31'd0, halted_o}, 32'd0);
        check("rst.count", fetch_count_o, 32'd0);

        tick();
        rst = 1'b0;
        tick();
        check("run0.addr", imem_addr_o, 32'h4);
        check_ifid("run0", 32'h8C01_0001, 32'h4, 1'b1);
        tick();
        check("run1.addr", imem_addr_o, 32'h8);
        check_ifid("run1", 32'h8C02_0002, 32'h8, 1'b1);
        check("run1.count", fetch_count_o, 32'd2);

        stall_i = 1'b1;
        tick();
        tick();
        check("stall.addr", imem_addr_o, 32'h8);
        check_ifid("stall", 32'h8C02_0002, 32'h8, 1'b1);
        check("stall.count", fetch_count_o, 32'd2);
        stall_i = 1'b0;
        tick();
        check("unstall.addr", imem_addr_o, 32'hC);
        check_ifid("unstall", 32'h8C03_0003, 32'hC, 1'b1);
        check("unstall.count", fetch_count_o, 32'd3);

        tick();
        tick();
        check("pre_flush.addr", imem_addr_o, 32'h14);
        flush_i = 1'b1;
        stall_i = 1'b1;
        tick();
        check("flush.addr", imem_addr_o, 32'h14);
        check_ifid("flush", 32'h8000_0000, 32'h0, 1'b0);
        check("flush.count", fetch_count_o, 32'd5);
        flush_i = 1'b0;

        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0000_0013;
        tick();
        check("br.addr", imem_addr_o, 32'h10);
        check_ifid("br", 32'h8000_0000, 32'h0, 1'b0);
        branch_taken_i = 1'b0;
        stall_i        = 1'b0;
        tick();
        check("post_br.addr", imem_addr_o, 32'h14);
        check_ifid("post_br", 32'h8C05_0005, 32'h14, 1'b1);
        check("post_br.count", fetch_count_o, 32'd6);

        for (int i = 0; i < 26; i++) tick();
        check("pc124.addr", imem_addr_o, 32'd124);
        check("pc124.count", fetch_count_o, 32'd32);
        tick();
        check("last.addr", imem_addr_o, 32'd128);
        check_ifid("last", 32'h8C20_0020, 32'd128, 1'b1);
        check("last.halted", {31'd0, halted_o}, 32'd0);
        tick();
        check("halt.addr", imem_addr_o, 32'd128);
        check("halt.halted", {31'd0, halted_o}, 32'd1);
        check_ifid("halt", 32'h8000_0000, 32'h0, 1'b0);
        check("halt.count", fetch_count_o, 32'd33);
        tick();
        check("halt2.addr", imem_addr_o, 32'd128);
        check("halt2.halted", {31'd0, halted_o}, 32'd1);
        check("halt2.count", fetch_count_o, 32'd33);

        branch_taken_i  = 1'b1;
        branch_target_i = 32'h0;
        tick();
        check("unhalt.addr", imem_addr_o, 32'h0);
        check("unhalt.halted", {31'd0, halted_o}, 32'd0);
        branch_taken_i = 1'b0;
        tick();
        check("resume.addr", imem_addr_o, 32'h4);
        check_ifid("resume", 32'h8C01_0001, 32'h4, 1'b1);
        check("resume.count", fetch_count_o, 32'd34);

        branch_taken_i  = 1'b1;
        branch_target_i = 32'd128;
        tick();
        branch_taken_i = 1'b0;
        tick();
        check("rehalt.halted", {31'd0, halted_o}, 32'd1);
        stall_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst.addr", imem_addr_o, 32'h0);
        check_ifid("arst", 32'h8000_0000, 32'h0, 1'b0);
        check("arst.halted", {31'd0, halted_o}, 32'd0);
        check("arst.count", fetch_count_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
